frv_pipeline_writeback: RTL and testbench
=========================================

Name: frv_pipeline_writeback

Overview:
- Final stage of the core pipeline. Consumes the s4_* outputs of the memory stage and the data-memory and MMIO responses.
- Matches each response to the LSU instruction in s4, then extracts and sign-extends load data.
- Produces a registered GPR write and a registered trap/retire indication.
- Tracks outstanding dmem requests so that responses belonging to flushed instructions are discarded.

Parameters:
- XLEN, 32: datapath width; XL = XLEN-1.
- MAX_OUTSTANDING, 2: maximum granted-but-unanswered dmem requests; counter width is clog2(MAX_OUTSTANDING+1).

Ports:
- g_clk in 1: global clock.
- g_resetn in 1: reset, asynchronous assert, active-low.
- flush in 1: discard the instruction in s4 and cancel any pending wait.
- s4_valid in 1: s4 holds an instruction.
- s4_busy out 1: stage cannot accept; s4 inputs must hold.
- s4_rd in 5: destination register, or trap cause when s4_trap=1.
- s4_opr_a in XLEN: result data; for LSU ops {27'b0, mmio, strb[3:0]}.
- s4_opr_b in XLEN: for LSU ops, the byte address.
- s4_uop in OP+1: micro-op; LSU_LOAD/LSU_STORE/LSU_SIGNED bits and width field [2:1].
- s4_fu in FU+1: functional-unit one-hot; P_FU_LSU selects the LSU path.
- s4_trap in 1: upstream trap.
- dmem_txn in 1: pulse; a dmem request was granted this cycle (dmem_req && dmem_gnt).
- dmem_recv in 1: dmem response valid.
- dmem_error in 1: dmem bus error, qualified by dmem_recv.
- dmem_rdata in XLEN: dmem read data.
- mmio_recv in 1: MMIO response valid.
- mmio_error in 1: MMIO error, qualified by mmio_recv.
- mmio_rdata in XLEN: MMIO read data.
- rsp_full out 1: outstanding count == MAX_OUTSTANDING; drives hold_lsu_req upstream.
- gpr_wen out 1: register-file write enable.
- gpr_rd out 5: register-file write address.
- gpr_wdata out XLEN: register-file write data.
- trap_valid out 1: trap raised.
- trap_cause out 6: trap cause.
- retire out 1: instruction retired without trap.

Behaviour:
- Reset: all outputs 0. State IDLE. Outstanding count 0, drop count 0, response buffer empty. Reset mid-wait abandons all tracking.
- Outstanding count: +1 on dmem_txn, -1 on dmem_recv; both in the same cycle leaves it unchanged. Overflow is not possible while upstream honours rsp_full.
- Drop count: on flush, drop := outstanding count minus any response consumed in that cycle. While drop > 0, each dmem_recv decrements drop and is discarded; it never fills the buffer.
- Response buffer: 1 entry {data, error}. Filled when dmem_recv arrives, drop == 0, and s4 holds no waiting LSU op. Consumed by the next dmem-path LSU instruction.
- FSM:
  - IDLE: s4_valid with a non-LSU op or s4_trap completes this cycle; s4_busy=0. An LSU op completes this cycle if a response (buffer, or dmem_recv/mmio_recv for mmio=opr_a[4]) is available; otherwise go to WAIT with s4_busy=1.
  - WAIT: s4_busy=1 until the matching response arrives, then complete and return to IDLE. flush returns to IDLE with no outputs.
- Completion registers outputs on the next edge (latency 1). Output pulses are single-cycle.
  - Non-LSU op: gpr_wen = (s4_rd != 0); gpr_wdata = s4_opr_a; retire = 1.
  - s4_trap: trap_valid = 1; trap_cause = {1'b0, s4_rd}; gpr_wen = 0.
  - Load: lane = opr_b[1:0].
    - Byte: rdata[8*lane +: 8].
    - Half: rdata[16*lane[1] +: 16].
    - Word: rdata.
    - Zero-extend unless LSU_SIGNED, then sign-extend.
    - gpr_wen = (rd != 0).
  - Store: retire only, no GPR write.
  - Response error: trap_valid = 1 with TRAP_LDACCESS or TRAP_STACCESS; gpr_wen = 0.
- Simultaneous events:
  - flush and response in the same cycle: the response is consumed against drop accounting, never written back.
  - flush has priority over completion.

Decomposition:
- Package frv_common.vh supplies: LSU_* uop fields, P_FU_* indices, TRAP_LDACCESS / TRAP_STACCESS, LEAK-independent constants.
- Sub-module frv_lsu_rsp_align: combinational lane select and extend (rdata, addr[1:0], width, signed -> wdata).

Test Plan:
- ALU op, s4_rd=5, opr_a=0x1234 -> next cycle gpr_wen=1, gpr_rd=5, gpr_wdata=0x1234, retire=1; s4_busy never asserted.
- Signed byte load, addr=0x...3, dmem_rdata=0x80FF_0000 arriving 3 cycles after s4_valid -> s4_busy=1 for 3 cycles, then gpr_wdata=0xFFFF_FF80.
- Unsigned half load, addr lane 2, rdata=0xBEEF_0001 -> gpr_wdata=0x0000_BEEF; rd=0 -> gpr_wen=0, retire=1.
- Two dmem_txn pulses -> rsp_full=1. flush before either response -> both later dmem_recv dropped; the next load waits for its own response.
- Store with dmem_recv && dmem_error -> trap_valid=1, trap_cause=TRAP_STACCESS, gpr_wen=0, retire=0.
- Response arriving the cycle before the load enters s4 is buffered -> the load completes with no stall. g_resetn asserted in WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/frv_pipeline_writeback_pkg.sv
// Shared encodings for the writeback stage: LSU micro-op fields, functional-unit
// indices, access-fault trap causes and the writeback FSM state type.
package frv_pipeline_writeback_pkg;

  localparam int OP = 4;
  localparam int FU = 4;

  localparam int LSU_SIGNED = 0;
  localparam int LSU_LOAD   = 3;
  localparam int LSU_STORE  = 4;

  localparam logic [1:0] LSU_BYTE = 2'b01;
  localparam logic [1:0] LSU_HALF = 2'b10;
  localparam logic [1:0] LSU_WORD = 2'b11;

  localparam int P_FU_ALU = 0;
  localparam int P_FU_MUL = 1;
  localparam int P_FU_LSU = 2;
  localparam int P_FU_CSR = 3;
  localparam int P_FU_CFU = 4;

  localparam logic [5:0] TRAP_LDACCESS = 6'd5;
  localparam logic [5:0] TRAP_STACCESS = 6'd7;

  typedef enum logic {
    WB_IDLE,
    WB_WAIT
  } wb_state_t;

endpackage

// File: rtl/frv_lsu_rsp_align.sv
// Load-data lane select and zero/sign extension for byte, half and word loads.
module frv_lsu_rsp_align
  import frv_pipeline_writeback_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr,
  input  logic [1:0]      width,
  input  logic            sign,
  output logic [XLEN-1:0] wdata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr, 3'b000} +: 8];
  assign half_sel = rdata[{addr[1], 4'b0000} +: 16];

  always_comb begin
    wdata = rdata;
    case (width)
      LSU_BYTE: wdata = {{(XLEN-8){sign & byte_sel[7]}}, byte_sel};
      LSU_HALF: wdata = {{(XLEN-16){sign & half_sel[15]}}, half_sel};
      default:  wdata = rdata;
    endcase
  end

endmodule

// File: rtl/frv_pipeline_writeback.sv
// Final pipeline stage: matches memory responses to the LSU op in s4, tracks
// outstanding dmem requests across flushes and registers GPR write / trap / retire.
module frv_pipeline_writeback
  import frv_pipeline_writeback_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            flush,
  input  logic            s4_valid,
  output logic            s4_busy,
  input  logic [4:0]      s4_rd,
  input  logic [XLEN-1:0] s4_opr_a,
  input  logic [XLEN-1:0] s4_opr_b,
  input  logic [OP:0]     s4_uop,
  input  logic [FU:0]     s4_fu,
  input  logic            s4_trap,
  input  logic            dmem_txn,
  input  logic            dmem_recv,
  input  logic            dmem_error,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            mmio_recv,
  input  logic            mmio_error,
  input  logic [XLEN-1:0] mmio_rdata,
  output logic            rsp_full,
  output logic            gpr_wen,
  output logic [4:0]      gpr_rd,
  output logic [XLEN-1:0] gpr_wdata,
  output logic            trap_valid,
  output logic [5:0]      trap_cause,
  output logic            retire
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  wb_state_t       state, state_nxt;
  logic [CW-1:0]   out_cnt, drop_cnt;
  logic            buf_valid, buf_err;
  logic [XLEN-1:0] buf_data;

  logic            lsu_op, mmio_op, dmem_live, take_buf, take_live, complete;
  logic            rsp_avail, rsp_err;
  logic [XLEN-1:0] rsp_data, load_data;

  logic            wen_nxt, trap_nxt, retire_nxt;
  logic [4:0]      rd_nxt;
  logic [XLEN-1:0] wdata_nxt;
  logic [5:0]      cause_nxt;

  logic            unused_ok;
  assign unused_ok = ^{s4_opr_b[XLEN-1:2], s4_fu[FU:P_FU_LSU+1], s4_fu[P_FU_LSU-1:0]};

  assign lsu_op    = s4_valid && s4_fu[P_FU_LSU] && !s4_trap;
  assign mmio_op   = s4_opr_a[4];
  assign dmem_live = dmem_recv && (drop_cnt == '0);
  assign take_buf  = lsu_op && !mmio_op && buf_valid;
  assign take_live = lsu_op && !mmio_op && !buf_valid && dmem_live;

  // The buffered response is older than anything arriving this cycle, so it wins.
  always_comb begin
    rsp_avail = 1'b0;
    rsp_err   = 1'b0;
    rsp_data  = dmem_rdata;
    if (mmio_op) begin
      rsp_avail = mmio_recv;
      rsp_err   = mmio_error;
      rsp_data  = mmio_rdata;
    end else if (buf_valid) begin
      rsp_avail = 1'b1;
      rsp_err   = buf_err;
      rsp_data  = buf_data;
    end else begin
      rsp_avail = dmem_live;
      rsp_err   = dmem_error;
    end
  end

  assign complete = s4_valid && !flush && (!lsu_op || rsp_avail);
  assign s4_busy  = lsu_op && !flush && !rsp_avail;
  assign rsp_full = (out_cnt == CW'(MAX_OUTSTANDING));

  frv_lsu_rsp_align #(.XLEN(XLEN)) u_align (
    .rdata (rsp_data),
    .addr  (s4_opr_b[1:0]),
    .width (s4_uop[2:1]),
    .sign  (s4_uop[LSU_SIGNED]),
    .wdata (load_data)
  );

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      out_cnt <= '0;
    end else if (dmem_txn && !dmem_recv) begin
      out_cnt <= out_cnt + CW'(1);
    end else if (dmem_recv && !dmem_txn && (out_cnt != '0)) begin
      out_cnt <= out_cnt - CW'(1);
    end
  end

  // On flush every still-outstanding response belongs to a killed instruction.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      drop_cnt <= '0;
    end else if (flush) begin
      drop_cnt <= (dmem_recv && (out_cnt != '0)) ? out_cnt - CW'(1) : out_cnt;
    end else if (dmem_recv && (drop_cnt != '0)) begin
      drop_cnt <= drop_cnt - CW'(1);
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      buf_valid <= 1'b0;
      buf_err   <= 1'b0;
      buf_data  <= '0;
    end else if (flush) begin
      buf_valid <= 1'b0;
    end else if (dmem_live && !take_live) begin
      buf_valid <= 1'b1;
      buf_err   <= dmem_error;
      buf_data  <= dmem_rdata;
    end else if (take_buf && complete) begin
      buf_valid <= 1'b0;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) state <= WB_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WB_IDLE: if (s4_busy) state_nxt = WB_WAIT;
      WB_WAIT: if (flush || !s4_busy) state_nxt = WB_IDLE;
      default: state_nxt = WB_IDLE;
    endcase
  end

  always_comb begin
    wen_nxt    = 1'b0;
    rd_nxt     = '0;
    wdata_nxt  = '0;
    trap_nxt   = 1'b0;
    cause_nxt  = '0;
    retire_nxt = 1'b0;
    if (complete) begin
      if (s4_trap) begin
        trap_nxt  = 1'b1;
        cause_nxt = {1'b0, s4_rd};
      end else if (lsu_op) begin
        if (rsp_err) begin
          trap_nxt  = 1'b1;
          cause_nxt = s4_uop[LSU_STORE] ? TRAP_STACCESS : TRAP_LDACCESS;
        end else if (s4_uop[LSU_LOAD]) begin
          wen_nxt    = (s4_rd != 5'd0);
          rd_nxt     = s4_rd;
          wdata_nxt  = load_data;
          retire_nxt = 1'b1;
        end else begin
          retire_nxt = 1'b1;
        end
      end else begin
        wen_nxt    = (s4_rd != 5'd0);
        rd_nxt     = s4_rd;
        wdata_nxt  = s4_opr_a;
        retire_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      gpr_wen    <= 1'b0;
      gpr_rd     <= '0;
      gpr_wdata  <= '0;
      trap_valid <= 1'b0;
      trap_cause <= '0;
      retire     <= 1'b0;
    end else begin
      gpr_wen    <= wen_nxt;
      gpr_rd     <= rd_nxt;
      gpr_wdata  <= wdata_nxt;
      trap_valid <= trap_nxt;
      trap_cause <= cause_nxt;
      retire     <= retire_nxt;
    end
  end

endmodule

// File: tb/tb_frv_pipeline_writeback.sv
// Directed bench for frv_pipeline_writeback: a vector table of single-shot ops plus
// hand-written stall, buffering, flush/drop and reset-in-wait sequences.
module tb_frv_pipeline_writeback;
  import frv_pipeline_writeback_pkg::*;

  localparam logic [4:0] FU_A = 5'b00001;
  localparam logic [4:0] FU_L = 5'b00100;

  logic        g_clk = 1'b0;
  logic        g_resetn, flush, s4_valid, s4_busy, s4_trap;
  logic [4:0]  s4_rd, gpr_rd;
  logic [31:0] s4_opr_a, s4_opr_b, dmem_rdata, mmio_rdata, gpr_wdata;
  logic [4:0]  s4_uop, s4_fu;
  logic        dmem_txn, dmem_recv, dmem_error, mmio_recv, mmio_error;
  logic        rsp_full, gpr_wen, trap_valid, retire;
  logic [5:0]  trap_cause;

  int total_checks = 0;
  int pass_checks  = 0;
  int busy_cycles;

  typedef struct {
    string       name;
    logic [4:0]  fu;
    logic [4:0]  uop;
    logic [4:0]  rd;
    logic [31:0] opr_a;
    logic [31:0] opr_b;
    logic        trap;
    logic        recv;
    logic        err;
    logic [31:0] rdata;
    logic        exp_wen;
    logic [4:0]  exp_rd;
    logic [31:0] exp_wdata;
    logic        exp_trap;
    logic [5:0]  exp_cause;
    logic        exp_retire;
  } vec_t;

  vec_t vecs[15];

  always #5 g_clk = ~g_clk;

  frv_pipeline_writeback #(.XLEN(32), .MAX_OUTSTANDING(2)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush), .s4_valid(s4_valid),
    .s4_busy(s4_busy), .s4_rd(s4_rd), .s4_opr_a(s4_opr_a), .s4_opr_b(s4_opr_b),
    .s4_uop(s4_uop), .s4_fu(s4_fu), .s4_trap(s4_trap), .dmem_txn(dmem_txn),
    .dmem_recv(dmem_recv), .dmem_error(dmem_error), .dmem_rdata(dmem_rdata),
    .mmio_recv(mmio_recv), .mmio_error(mmio_error), .mmio_rdata(mmio_rdata),
    .rsp_full(rsp_full), .gpr_wen(gpr_wen), .gpr_rd(gpr_rd), .gpr_wdata(gpr_wdata),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .retire(retire)
  );

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_checks++;
    if (actual === expected) pass_checks++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
  endtask

  task automatic checkRegs(input string tag, input logic wen, input logic [4:0] rd, input logic [31:0] wdata,
                           input logic tv, input logic [5:0] cause, input logic ret);
    checkOutput({tag, ".gpr_wen"},    32'(gpr_wen),    32'(wen));
    checkOutput({tag, ".gpr_rd"},     32'(gpr_rd),     32'(rd));
    checkOutput({tag, ".gpr_wdata"},  gpr_wdata,       wdata);
    checkOutput({tag, ".trap_valid"}, 32'(trap_valid), 32'(tv));
    checkOutput({tag, ".trap_cause"}, 32'(trap_cause), 32'(cause));
    checkOutput({tag, ".retire"},     32'(retire),     32'(ret));
  endtask

  task automatic clearInputs();
    flush = 1'b0; s4_valid = 1'b0; s4_rd = 5'd0; s4_opr_a = 32'h0; s4_opr_b = 32'h0;
    s4_uop = 5'h0; s4_fu = 5'h0; s4_trap = 1'b0; dmem_txn = 1'b0; dmem_recv = 1'b0;
    dmem_error = 1'b0; dmem_rdata = 32'h0; mmio_recv = 1'b0; mmio_error = 1'b0; mmio_rdata = 32'h0;
  endtask

  task automatic nextCycle();
    @(posedge g_clk);
    #1;
  endtask

  task automatic setOp(input logic [4:0] fu, input logic [4:0] uop, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b);
    s4_valid = 1'b1; s4_fu = fu; s4_uop = uop; s4_rd = rd; s4_opr_a = a; s4_opr_b = b;
  endtask

  task automatic applyStimulus(input vec_t v);
    logic is_dmem;
    is_dmem = v.fu[P_FU_LSU] && !v.opr_a[4] && !v.trap;
    clearInputs();
    if (is_dmem) begin
      dmem_txn = 1'b1;
      nextCycle();
      dmem_txn = 1'b0;
    end
    setOp(v.fu, v.uop, v.rd, v.opr_a, v.opr_b);
    s4_trap = v.trap;
    if (v.fu[P_FU_LSU] && v.opr_a[4]) begin
      mmio_recv = v.recv; mmio_error = v.err; mmio_rdata = v.rdata;
    end else begin
      dmem_recv = v.recv; dmem_error = v.err; dmem_rdata = v.rdata;
    end
    #3;
    checkOutput({v.name, ".s4_busy"}, 32'(s4_busy), 32'd0);
    nextCycle();
    clearInputs();
    checkRegs(v.name, v.exp_wen, v.exp_rd, v.exp_wdata, v.exp_trap, v.exp_cause, v.exp_retire);
  endtask

  initial begin
    vecs[0]  = '{"alu_rd5",     FU_A, 5'h00, 5'd5,  32'h1234, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 5'd5,  32'h1234,     1'b0, 6'd0, 1'b1};
    vecs[1]  = '{"alu_rd0",     FU_A, 5'h00, 5'd0,  32'hDEAD, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 5'd0,  32'hDEAD,     1'b0, 6'd0, 1'b1};
    vecs[2]  = '{"upstream_trap", FU_A, 5'h00, 5'd2, 32'h77,  32'h0,    1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 6'd2, 1'b0};
    vecs[3]  = '{"lhu_lane2_rd0", FU_L, 5'h0C, 5'd0, 32'h3,   32'h2002, 1'b0, 1'b1, 1'b0, 32'hBEEF0001, 1'b0, 5'd0,  32'h0000BEEF, 1'b0, 6'd0, 1'b1};
    vecs[4]  = '{"lb_lane1",    FU_L, 5'h0B, 5'd7,  32'h2,    32'h1001, 1'b0, 1'b1, 1'b0, 32'h00008000, 1'b1, 5'd7,  32'hFFFFFF80, 1'b0, 6'd0, 1'b1};
    vecs[5]  = '{"lbu_lane0",   FU_L, 5'h0A, 5'd3,  32'h1,    32'h1000, 1'b0, 1'b1, 1'b0, 32'h123456F0, 1'b1, 5'd3,  32'h000000F0, 1'b0, 6'd0, 1'b1};
    vecs[6]  = '{"lh_lane0_pos", FU_L, 5'h0D, 5'd4, 32'h3,    32'h0,    1'b0, 1'b1, 1'b0, 32'h00007FFF, 1'b1, 5'd4,  32'h00007FFF, 1'b0, 6'd0, 1'b1};
    vecs[7]  = '{"lh_lane2_neg", FU_L, 5'h0D, 5'd9, 32'hC,    32'h2,    1'b0, 1'b1, 1'b0, 32'h80010000, 1'b1, 5'd9,  32'hFFFF8001, 1'b0, 6'd0, 1'b1};
    vecs[8]  = '{"lw",          FU_L, 5'h0E, 5'd10, 32'hF,    32'h4,    1'b0, 1'b1, 1'b0, 32'hCAFEBABE, 1'b1, 5'd10, 32'hCAFEBABE, 1'b0, 6'd0, 1'b1};
    vecs[9]  = '{"sw_ok",       FU_L, 5'h16, 5'd0,  32'hF,    32'h8,    1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 6'd0, 1'b1};
    vecs[10] = '{"sw_err",      FU_L, 5'h16, 5'd0,  32'hF,    32'h8,    1'b0, 1'b1, 1'b1, 32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 6'd7, 1'b0};
    vecs[11] = '{"lw_err",      FU_L, 5'h0E, 5'd5,  32'hF,    32'h0,    1'b0, 1'b1, 1'b1, 32'h12345678, 1'b0, 5'd0,  32'h0,        1'b1, 6'd5, 1'b0};
    vecs[12] = '{"mmio_lb",     FU_L, 5'h0B, 5'd6,  32'h11,   32'h0,    1'b0, 1'b1, 1'b0, 32'h000000A5, 1'b1, 5'd6,  32'hFFFFFFA5, 1'b0, 6'd0, 1'b1};
    vecs[13] = '{"mmio_sw_err", FU_L, 5'h16, 5'd0,  32'h1F,   32'h0,    1'b0, 1'b1, 1'b1, 32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 6'd7, 1'b0};
    vecs[14] = '{"lsu_trap",    FU_L, 5'h0E, 5'd4,  32'hF,    32'h0,    1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 6'd4, 1'b0};

    clearInputs();
    g_resetn = 1'b0;
    repeat (2) nextCycle();
    checkRegs("reset", 1'b0, 5'd0, 32'h0, 1'b0, 6'd0, 1'b0);
    checkOutput("reset.rsp_full", 32'(rsp_full), 32'd0);
    g_resetn = 1'b1;
    nextCycle();

    for (int i = 0; i < 15; i++) applyStimulus(vecs[i]);

    // Signed byte load in lane 3 whose response lands three cycles late.
    dmem_txn = 1'b1;
    nextCycle();
    dmem_txn = 1'b0;
    setOp(FU_L, 5'h0B, 5'd8, 32'h1, 32'h00001003);
    busy_cycles = 0;
    for (int c = 0; c < 3; c++) begin
      #3;
      if (s4_busy) busy_cycles++;
      nextCycle();
      checkOutput("stall.no_wen", 32'(gpr_wen), 32'd0);
    end
    dmem_recv = 1'b1; dmem_rdata = 32'h80FF0000;
    #3;
    checkOutput("stall.busy_release", 32'(s4_busy), 32'd0);
    nextCycle();
    clearInputs();
    checkOutput("stall.busy_cycles", 32'(busy_cycles), 32'd3);
    checkRegs("stall", 1'b1, 5'd8, 32'hFFFFFF80, 1'b0, 6'd0, 1'b1);

    // Response arriving before its load reaches s4 is buffered.
    dmem_txn = 1'b1;
    nextCycle();
    dmem_txn = 1'b0; dmem_recv = 1'b1; dmem_rdata = 32'h000000C3;
    nextCycle();
    clearInputs();
    checkRegs("buf.early", 1'b0, 5'd0, 32'h0, 1'b0, 6'd0, 1'b0);
    setOp(FU_L, 5'h0A, 5'd12, 32'h1, 32'h0);
    #3;
    checkOutput("buf.busy", 32'(s4_busy), 32'd0);
    nextCycle();
    clearInputs();
    checkRegs("buf", 1'b1, 5'd12, 32'h000000C3, 1'b0, 6'd0, 1'b1);

    // Flush with two requests in flight: both responses are dropped.
    dmem_txn = 1'b1;
    nextCycle();
    nextCycle();
    dmem_txn = 1'b0;
    checkOutput("flush.rsp_full", 32'(rsp_full), 32'd1);
    flush = 1'b1;
    nextCycle();
    flush = 1'b0;
    dmem_recv = 1'b1; dmem_rdata = 32'h0000BAD0;
    #3;
    checkOutput("flush.full_pending", 32'(rsp_full), 32'd1);
    nextCycle();
    dmem_recv = 1'b0;
    checkRegs("flush.drop0", 1'b0, 5'd0, 32'h0, 1'b0, 6'd0, 1'b0);
    dmem_txn = 1'b1;
    nextCycle();
    dmem_txn = 1'b0;
    setOp(FU_L, 5'h0E, 5'd11, 32'h1, 32'h0);
    dmem_recv = 1'b1; dmem_rdata = 32'h0000BAD1;
    #3;
    checkOutput("flush.busy_on_drop", 32'(s4_busy), 32'd1);
    nextCycle();
    checkRegs("flush.drop1", 1'b0, 5'd0, 32'h0, 1'b0, 6'd0, 1'b0);
    dmem_rdata = 32'h11223344;
    #3;
    checkOutput("flush.busy_own", 32'(s4_busy), 32'd0);
    nextCycle();
    clearInputs();
    checkRegs("flush.own", 1'b1, 5'd11, 32'h11223344, 1'b0, 6'd0, 1'b1);
    checkOutput("flush.full_clear", 32'(rsp_full), 32'd0);

    // Reset while waiting abandons all tracking; the held load then completes normally.
    dmem_txn = 1'b1;
    nextCycle();
    setOp(FU_A, 5'h00, 5'd1, 32'h55, 32'h0);
    nextCycle();
    dmem_txn = 1'b0;
    checkOutput("rst.pre_wen", 32'(gpr_wen), 32'd1);
    checkOutput("rst.pre_full", 32'(rsp_full), 32'd1);
    setOp(FU_L, 5'h0E, 5'd13, 32'h1, 32'h0);
    #3;
    checkOutput("rst.busy", 32'(s4_busy), 32'd1);
    nextCycle();
    g_resetn = 1'b0;
    #1;
    checkRegs("rst.in_wait", 1'b0, 5'd0, 32'h0, 1'b0, 6'd0, 1'b0);
    checkOutput("rst.rsp_full", 32'(rsp_full), 32'd0);
    nextCycle();
    g_resetn = 1'b1;
    dmem_recv = 1'b1; dmem_rdata = 32'h0BADF00D;
    #2;
    checkOutput("rst.after_busy", 32'(s4_busy), 32'd0);
    nextCycle();
    clearInputs();
    checkRegs("rst.after", 1'b1, 5'd13, 32'h0BADF00D, 1'b0, 6'd0, 1'b1);

    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule
